// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP writeback slice: FSM state codes and default geometry.
package sfp_pkg;

  // Default tile geometry.
  localparam int col     = 8;
  localparam int psum_bw = 16;
  localparam int NUM_OUT = 16;

  // Writeback FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

endpackage

// File: rtl/sfp_wb_fifo.sv
// Small synchronous skid FIFO between the SFP output and the activation SRAM write port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sfp_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   wr_q, rd_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  // Status, head and qualified push/pop; a push on full is only taken alongside a pop.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | pop);
    // Zero when empty so the write-data bus idles at a defined value.
    head    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  // Read/write pointer update; clr flushes the contents.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrOne;
      if (do_pop)  rd_q <= rd_q + PtrOne;
    end
  end

  // Storage write; contents need no reset because head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sfp_writeback.sv
// SFP drain-side writeback: buffers ReLU'd output rows and writes them to the output-activation
// SRAM at consecutive addresses from a programmed base, yielding to host reads.
// Optional feature: define SFP_WB_CHKSUM_EN to add the running-XOR `chksum` output.
module sfp_writeback #(
  parameter int col       = sfp_pkg::col,
  parameter int psum_bw   = sfp_pkg::psum_bw,
  parameter int NUM_OUT   = sfp_pkg::NUM_OUT,
  parameter int ADDR_W    = 11,
  parameter int BUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic                           in_valid,
  input  logic [col*psum_bw-1:0]         in_data,
  input  logic                           mem_busy,
  output logic                           mem_cen,
  output logic                           mem_wen,
  output logic [ADDR_W-1:0]              mem_a,
  output logic [col*psum_bw-1:0]         mem_d,
  output logic                           busy,
  output logic                           done,
  output logic                           ovf,
`ifdef SFP_WB_CHKSUM_EN
  output logic [col*psum_bw-1:0]         chksum,
`endif
  output logic [$clog2(NUM_OUT+1)-1:0]   wr_count
);

  import sfp_pkg::*;

  localparam int DW = col * psum_bw;
  localparam int CW = $clog2(NUM_OUT + 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntLast = CW'(NUM_OUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic              ovf_q, ovf_d;
`ifdef SFP_WB_CHKSUM_EN
  logic [DW-1:0]     chk_q, chk_d;
`endif

  logic          active, wr_en, push_req;
  logic          fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_head;

  sfp_wb_fifo #(
    .DEPTH (BUF_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Write issue and FIFO handshake, all combinational from state and the host busy line.
  always_comb begin
    active    = (state_q == StRun) || (state_q == StDrain);
    wr_en     = active & ~fifo_empty & ~mem_busy;
    push_req  = (state_q == StRun) & in_valid;
    fifo_pop  = wr_en;
    // A full buffer still accepts when the head commits on the same edge.
    fifo_push = push_req & (~fifo_full | wr_en);
  end

  // Next-state: counters, sticky overflow, checksum and FSM sequencing.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    wr_cnt_d = wr_cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    fifo_clr = 1'b0;
`ifdef SFP_WB_CHKSUM_EN
    chk_d    = chk_q;
`endif

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + CntOne;
`ifdef SFP_WB_CHKSUM_EN
      chk_d    = chk_q ^ fifo_head;
`endif
    end
    if (fifo_push) acc_d = acc_q + CntOne;
    if (push_req && fifo_full && !wr_en) ovf_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          base_d   = base_addr;
          wr_cnt_d = '0;
          acc_d    = '0;
          ovf_d    = 1'b0;
          fifo_clr = 1'b1;
`ifdef SFP_WB_CHKSUM_EN
          chk_d    = '0;
`endif
        end
      end
      StRun:   if (acc_d == CntLast) state_d = StDrain;
      StDrain: if (wr_cnt_d == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      base_q   <= '0;
      wr_cnt_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef SFP_WB_CHKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      wr_cnt_q <= wr_cnt_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
`ifdef SFP_WB_CHKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  // Output mapping; address wraps modulo 2^ADDR_W.
  always_comb begin
    mem_cen  = ~wr_en;
    mem_wen  = ~wr_en;
    mem_a    = base_q + ADDR_W'(wr_cnt_q);
    mem_d    = fifo_head;
    busy     = active;
    done     = (state_q == StDone);
    ovf      = ovf_q;
    wr_count = wr_cnt_q;
`ifdef SFP_WB_CHKSUM_EN
    chksum   = chk_q;
`endif
  end

endmodule
